reg_file_reader: RTL and testbench

Sequential read-out engine for the 16 x 16-bit register file: on a start pulse it walks a configurable address range, using the file's two combinational read ports (A and B) to fetch registers in pairs. It streams each word out over a valid/ready handshake together with its address. On completion it reports a running 16-bit checksum. It sits on the read side of the register file, opposite the C/load write port, and serves dump, debug and self-test paths.

---
 rtl/reg_file_reader.sv | 134 +++++++++++++
 tb/tb_reg_file_reader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_reader.sv
// Walks FIRST_ADDR..LAST_ADDR of the register file two words per fetch and streams each word with its address.
// Latency: first word valid two cycles after start is sampled; three cycles per pair with out_ready held high.
// Backpressure: while out_valid is high and out_ready is low, the word, pointer and checksum all hold.
module reg_file_reader #(
    parameter int FIRST_ADDR = 0,
    parameter int LAST_ADDR  = 15
) (
    input  logic        clk,
    input  logic        nClear,
    input  logic        start,
    output logic [3:0]  Aaddr,
    output logic [3:0]  Baddr,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] out_data,
    output logic [3:0]  out_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] checksum
);

    localparam logic [3:0] FIRST = 4'(FIRST_ADDR);
    localparam logic [3:0] LAST  = 4'(LAST_ADDR);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        SEND_A = 3'd2,
        SEND_B = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t      state;
    logic [3:0]  ptr;
    logic [15:0] hold_a;
    logic [15:0] hold_b;
    logic [3:0]  ptr_p1;
    logic [3:0]  ptr_p2;
    logic [3:0]  ptr_p3;
    logic        accept;

    // All pointer arithmetic wraps at 16 registers.
    assign ptr_p1 = ptr + 4'd1;
    assign ptr_p2 = ptr + 4'd2;
    assign ptr_p3 = ptr + 4'd3;
    assign accept = out_valid & out_ready;

    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            state     <= IDLE;
            ptr       <= FIRST;
            Aaddr     <= FIRST;
            Baddr     <= FIRST + 4'd1;
            hold_a    <= '0;
            hold_b    <= '0;
            out_data  <= '0;
            out_addr  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            checksum  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr      <= FIRST;
                        Aaddr    <= FIRST;
                        Baddr    <= FIRST + 4'd1;
                        checksum <= '0;
                        busy     <= 1'b1;
                        state    <= READ;
                    end
                end

                READ: begin
                    // Both ports are combinational, so A/B already reflect ptr and ptr+1.
                    hold_a    <= A;
                    hold_b    <= B;
                    out_data  <= A;
                    out_addr  <= ptr;
                    out_valid <= 1'b1;
                    state     <= SEND_A;
                end

                SEND_A: begin
                    if (accept) begin
                        checksum <= checksum + hold_a;
                        if (ptr == LAST) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            out_data <= hold_b;
                            out_addr <= ptr_p1;
                            state    <= SEND_B;
                        end
                    end
                end

                SEND_B: begin
                    if (accept) begin
                        checksum  <= checksum + hold_b;
                        out_valid <= 1'b0;
                        if (ptr_p1 == LAST) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            ptr   <= ptr_p2;
                            Aaddr <= ptr_p2;
                            Baddr <= ptr_p3;
                            state <= READ;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_reader.sv
// Bench for reg_file_reader: three instances (full range, 3..7, 15..15) share one modelled register file.
module tb_reg_file_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nclear;
    logic [2:0]  start;
    logic        out_ready;
    logic [15:0] rf [16];

    logic [3:0]  aaddr [3];
    logic [3:0]  baddr [3];
    logic [15:0] odata [3];
    logic [3:0]  oaddr [3];
    logic [15:0] ocks  [3];
    logic [2:0]  ovalid;
    logic [2:0]  obusy;
    logic [2:0]  odone;

    reg_file_reader #(.FIRST_ADDR(0), .LAST_ADDR(15)) u_full (
        .clk(clk), .nClear(nclear), .start(start[0]),
        .Aaddr(aaddr[0]), .Baddr(baddr[0]), .A(rf[aaddr[0]]), .B(rf[baddr[0]]),
        .out_data(odata[0]), .out_addr(oaddr[0]), .out_valid(ovalid[0]), .out_ready(out_ready),
        .busy(obusy[0]), .done(odone[0]), .checksum(ocks[0])
    );

    reg_file_reader #(.FIRST_ADDR(3), .LAST_ADDR(7)) u_mid (
        .clk(clk), .nClear(nclear), .start(start[1]),
        .Aaddr(aaddr[1]), .Baddr(baddr[1]), .A(rf[aaddr[1]]), .B(rf[baddr[1]]),
        .out_data(odata[1]), .out_addr(oaddr[1]), .out_valid(ovalid[1]), .out_ready(out_ready),
        .busy(obusy[1]), .done(odone[1]), .checksum(ocks[1])
    );

    reg_file_reader #(.FIRST_ADDR(15), .LAST_ADDR(15)) u_one (
        .clk(clk), .nClear(nclear), .start(start[2]),
        .Aaddr(aaddr[2]), .Baddr(baddr[2]), .A(rf[aaddr[2]]), .B(rf[baddr[2]]),
        .out_data(odata[2]), .out_addr(oaddr[2]), .out_valid(ovalid[2]), .out_ready(out_ready),
        .busy(obusy[2]), .done(odone[2]), .checksum(ocks[2])
    );

    logic [1:0]  sel;
    logic        ov, bz, dn;
    logic [15:0] od, ck;
    logic [3:0]  oa;

    always_comb begin
        ov = 1'b0; bz = 1'b0; dn = 1'b0; od = '0; ck = '0; oa = '0;
        for (int i = 0; i < 3; i++) begin
            if (sel == 2'(i)) begin
                ov = ovalid[i]; bz = obusy[i]; dn = odone[i];
                od = odata[i];  oa = oaddr[i]; ck = ocks[i];
            end
        end
    end

    int checks = 0;
    int failures = 0;
    int cyc, first_v, done_cnt, done_cyc;
    logic [19:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // One clock: pop/compare any word handshaking at this edge, then check stall stability.
    task automatic step();
        logic        stalled;
        logic [19:0] held;
        logic [19:0] e;
        stalled = ov && !out_ready;
        held = {oa, od};
        if (ov && out_ready) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("word", 32'({oa, od}), 32'(e));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (stalled) check("stall_hold", 32'({ov, oa, od}), 32'({1'b1, held}));
        if (ov && first_v == 0) first_v = cyc;
        if (dn) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = cyc;
        end
    endtask

    task automatic run_dump(input int s, input int first, input int last, input bit toggle,
                            input int mid_start, input int exp_done);
        logic [15:0] sum;
        int k;
        sel = 2'(s);
        sum = '0;
        for (int a = first; a <= last; a++) begin
            exp_q.push_back({4'(a), rf[a]});
            sum += rf[a];
        end
        cyc = 0; first_v = 0; done_cnt = 0; done_cyc = 0;
        out_ready = 1'b1;
        start[s] = 1'b1;
        step();
        start[s] = 1'b0;
        k = 0;
        while (done_cyc == 0 && cyc < 300) begin
            out_ready = toggle ? (k % 3 == 0) : 1'b1;
            start[s] = (cyc == mid_start);
            k++;
            step();
        end
        start[s] = 1'b0;
        out_ready = 1'b1;
        check("done_seen", 32'(done_cyc != 0), 32'd1);
        check("first_valid_cycle", 32'(first_v), 32'd2);
        if (exp_done > 0) check("done_cycle", 32'(done_cyc), 32'(exp_done));
        check("all_words_out", 32'(exp_q.size()), 32'd0);
        check("checksum", 32'(ck), 32'(sum));
        check("busy_in_done", 32'(bz), 32'd1);
        step();
        check("done_one_cycle", 32'(dn), 32'd0);
        check("done_count", 32'(done_cnt), 32'd1);
        check("idle_not_busy", 32'(bz), 32'd0);
        check("checksum_hold", 32'(ck), 32'(sum));
        exp_q.delete();
    endtask

    initial begin
        nclear = 1'b1;
        start = '0;
        out_ready = 1'b0;
        sel = 2'd0;
        for (int i = 0; i < 16; i++) rf[i] = '0;
        #1 nclear = 1'b0;
        #1;
        check("rst_aaddr0", 32'(aaddr[0]), 32'd0);
        check("rst_baddr0", 32'(baddr[0]), 32'd1);
        check("rst_aaddr1", 32'(aaddr[1]), 32'd3);
        check("rst_baddr1", 32'(baddr[1]), 32'd4);
        check("rst_aaddr2", 32'(aaddr[2]), 32'd15);
        check("rst_baddr2_wrap", 32'(baddr[2]), 32'd0);
        check("rst_valid", 32'(ovalid), 32'd0);
        check("rst_busy", 32'(obusy), 32'd0);
        check("rst_done", 32'(odone), 32'd0);
        check("rst_out", 32'({oaddr[0], odata[0]}), 32'd0);
        check("rst_checksum", 32'(ocks[0]), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        nclear = 1'b1;

        // Full dump, out_ready high.
        for (int i = 0; i < 16; i++) rf[i] = 16'(i + 1);
        run_dump(0, 0, 15, 1'b0, -1, 25);

        // Same contents under 1,0,0 backpressure.
        run_dump(0, 0, 15, 1'b1, -1, 0);

        // Sub-range 3..7; B fetch of 8 must never appear.
        for (int i = 0; i < 16; i++) rf[i] = 16'h1000 + 16'(i);
        run_dump(1, 3, 7, 1'b0, -1, 9);

        // Single word at 15 with B wrapping to 0.
        rf[15] = 16'hFFFF;
        rf[0]  = 16'h1234;
        run_dump(2, 15, 15, 1'b0, -1, 3);

        // Checksum wraps to zero; a start pulse mid-dump is ignored.
        for (int i = 0; i < 16; i++) rf[i] = 16'hF000;
        run_dump(0, 0, 15, 1'b0, 7, 25);

        // Reset during a stalled SEND_B of address 5.
        for (int i = 0; i < 16; i++) rf[i] = 16'(i + 1);
        sel = 2'd0;
        for (int a = 0; a < 16; a++) exp_q.push_back({4'(a), rf[a]});
        cyc = 0; first_v = 0; done_cnt = 0; done_cyc = 0;
        out_ready = 1'b1;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        while (!(ov && oa == 4'd5) && cyc < 100) step();
        check("reach_addr5", 32'({ov, oa}), 32'({1'b1, 4'd5}));
        out_ready = 1'b0;
        step();
        step();
        check("stalled_valid", 32'(ov), 32'd1);
        #2 nclear = 1'b0;
        #1;
        check("abort_valid", 32'(ov), 32'd0);
        check("abort_busy", 32'(bz), 32'd0);
        check("abort_checksum", 32'(ck), 32'd0);
        step();
        step();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        nclear = 1'b1;
        exp_q.delete();
        run_dump(0, 0, 15, 1'b0, -1, 25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
